// File: rtl/controlador_estados_param_pkg.sv
// Shared definitions for the Tamagotchi activity controller: one-hot state
// encoding (reused by the display/animation blocks) and a width helper.
package controlador_estados_param_pkg;

  typedef enum logic [3:0] {
    IDLE       = 4'b0000,
    DORMINDO   = 4'b0001,
    COMENDO    = 4'b0010,
    DANDO_AULA = 4'b0100,
    MORTO      = 4'b1000
  } estado_e;

  // Counters must be at least one bit wide even when the range collapses.
  function automatic int largura_min1(input int w);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/controlador_estados_param_amostrador_botao.sv
// Button sampler: 2-flop synchroniser, level sampled on each prescaler tick,
// and a one-cycle press pulse on a sampled rising edge.
module amostrador_botao (
  input  logic clk,
  input  logic rst_n,
  input  logic botao_i,
  input  logic tick_i,
  output logic press_o
);

  logic sinc1_q, sinc2_q, amostra_q, press_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sinc1_q   <= 1'b0;
      sinc2_q   <= 1'b0;
      amostra_q <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      sinc1_q <= botao_i;
      sinc2_q <= sinc1_q;
      if (tick_i) amostra_q <= sinc2_q;
      // A held button keeps amostra high, so it can only fire once.
      press_q <= tick_i & sinc2_q & ~amostra_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/controlador_estados_param.sv
// Tamagotchi activity-state controller: sampled buttons and vital levels
// select the pet's state, with action timeout, low-vital alert and change pulse.
module controlador_estados_param
  import controlador_estados_param_pkg::*;
#(
  parameter int LARGURA         = 8,
  parameter int PERIODO_AMOSTRA = 65536,
  parameter int DURACAO_ACAO    = 1024,
  parameter int LIMIAR_ALERTA   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               b1,
  input  logic               b2,
  input  logic [LARGURA-1:0] fome,
  input  logic [LARGURA-1:0] felicidade,
  input  logic [LARGURA-1:0] sono,
  output logic [3:0]         estado,
  output logic               alerta,
  output logic               evento
);

  localparam int PW = largura_min1($clog2(PERIODO_AMOSTRA));
  localparam int TW = largura_min1($clog2(DURACAO_ACAO + 1));

  logic [PW-1:0] presc_q;
  logic          tick;
  logic [1:0]    botoes, press;
  estado_e       estado_q, estado_d;
  logic [TW-1:0] tmr_q;
  logic          alerta_q, evento_q;
  logic          vital_zero, vital_baixo, em_acao, expirou;

  assign tick   = (presc_q == PW'(PERIODO_AMOSTRA - 1));
  assign botoes = {b2, b1};

  for (genvar gi = 0; gi < 2; gi++) begin : g_botao
    amostrador_botao u_amostrador (
      .clk    (clk),
      .rst_n  (rst_n),
      .botao_i(botoes[gi]),
      .tick_i (tick),
      .press_o(press[gi])
    );
  end

  assign vital_zero  = (fome == '0) || (felicidade == '0) || (sono == '0);
  assign vital_baixo = ((fome != '0) && (32'(fome) <= 32'(LIMIAR_ALERTA))) ||
                       ((felicidade != '0) && (32'(felicidade) <= 32'(LIMIAR_ALERTA))) ||
                       ((sono != '0) && (32'(sono) <= 32'(LIMIAR_ALERTA)));
  assign em_acao     = (estado_q == DORMINDO) || (estado_q == COMENDO) ||
                       (estado_q == DANDO_AULA);
  assign expirou     = (DURACAO_ACAO != 0) && (32'(tmr_q) == 32'(DURACAO_ACAO - 1));

  always_comb begin
    estado_d = estado_q;
    if (estado_q == MORTO || vital_zero) begin
      estado_d = MORTO;
    end else begin
      case (estado_q)
        IDLE: begin
          if (press[0] && press[1]) estado_d = DANDO_AULA;
          else if (press[0])        estado_d = COMENDO;
          else if (press[1])        estado_d = DORMINDO;
        end
        DORMINDO, COMENDO, DANDO_AULA: begin
          if (press != 2'b00 || expirou) estado_d = IDLE;
        end
        // Non-one-hot encodings recover to IDLE.
        default: estado_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= '0;
      estado_q <= IDLE;
      tmr_q    <= '0;
      alerta_q <= 1'b0;
      evento_q <= 1'b0;
    end else begin
      presc_q  <= tick ? '0 : presc_q + PW'(1);
      estado_q <= estado_d;
      evento_q <= (estado_d != estado_q);
      alerta_q <= (estado_d != MORTO) && vital_baixo;
      if (estado_d != estado_q)         tmr_q <= '0;
      else if (em_acao && tmr_q != '1)  tmr_q <= tmr_q + TW'(1);
    end
  end

  assign estado = estado_q;
  assign alerta = alerta_q;
  assign evento = evento_q;

endmodule

// File: tb/tb_controlador_estados_param.sv
// Randomised + directed bench: two DUTs (timeout 8 and timeout disabled)
// share stimulus and are compared every cycle against a behavioural model.
module tb_controlador_estados_param;

  localparam int P = 4;
  localparam int LIM = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       b1 = 1'b0, b2 = 1'b0;
  logic [7:0] fome = 8'd100, felicidade = 8'd100, sono = 8'd100;
  logic [3:0] estado_a, estado_z;
  logic       alerta_a, alerta_z, evento_a, evento_z;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: shared button path, per-DUT activity state (0 idle,1 dorm,2 com,3 aula,4 morto)
  int m_s1[2], m_s2[2], m_am[2], m_pr[2], m_presc;
  int m_st[2], m_tm[2], m_al[2], m_ev[2];
  int m_dur[2] = '{8, 0};

  controlador_estados_param #(.LARGURA(8), .PERIODO_AMOSTRA(P), .DURACAO_ACAO(8),
                              .LIMIAR_ALERTA(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .b1(b1), .b2(b2), .fome(fome), .felicidade(felicidade),
    .sono(sono), .estado(estado_a), .alerta(alerta_a), .evento(evento_a));

  controlador_estados_param #(.LARGURA(8), .PERIODO_AMOSTRA(P), .DURACAO_ACAO(0),
                              .LIMIAR_ALERTA(LIM)) dut0 (
    .clk(clk), .rst_n(rst_n), .b1(b1), .b2(b2), .fome(fome), .felicidade(felicidade),
    .sono(sono), .estado(estado_z), .alerta(alerta_z), .evento(evento_z));

  initial forever #5 clk = ~clk;

  function automatic logic [3:0] to_oh(input int s);
    case (s)
      1: return 4'b0001;
      2: return 4'b0010;
      3: return 4'b0100;
      4: return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_s1[k] = 0; m_s2[k] = 0; m_am[k] = 0; m_pr[k] = 0;
      m_st[k] = 0; m_tm[k] = 0; m_al[k] = 0; m_ev[k] = 0;
    end
    m_presc = 0;
  endtask

  function automatic bit low_v(input logic [7:0] v);
    return (v != 0) && (int'(v) <= LIM);
  endfunction

  task automatic m_step();
    int  raw[2];
    int  p[2];
    int  nxt;
    bit  tick, dead, low;
    raw[0] = int'(b1); raw[1] = int'(b2);
    p = m_pr;
    tick = (m_presc == P - 1);
    for (int k = 0; k < 2; k++) begin
      m_pr[k] = (tick && m_s2[k] == 1 && m_am[k] == 0) ? 1 : 0;
      if (tick) m_am[k] = m_s2[k];
      m_s2[k] = m_s1[k];
      m_s1[k] = raw[k];
    end
    m_presc = tick ? 0 : m_presc + 1;
    dead = (fome == 0) || (felicidade == 0) || (sono == 0);
    low  = low_v(fome) || low_v(felicidade) || low_v(sono);
    for (int i = 0; i < 2; i++) begin
      if (m_st[i] == 4 || dead)             nxt = 4;
      else if (m_st[i] == 0)                nxt = (p[0] == 1 && p[1] == 1) ? 3 :
                                                  (p[0] == 1) ? 2 : (p[1] == 1) ? 1 : 0;
      else if (p[0] == 1 || p[1] == 1)      nxt = 0;
      else if (m_dur[i] != 0 && m_tm[i] == m_dur[i] - 1) nxt = 0;
      else                                  nxt = m_st[i];
      m_ev[i] = (nxt != m_st[i]) ? 1 : 0;
      if (nxt != m_st[i]) m_tm[i] = 0;
      else if (m_st[i] != 0) m_tm[i]++;
      m_al[i] = (nxt != 4 && low) ? 1 : 0;
      m_st[i] = nxt;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  initial forever begin
    @(negedge clk);
    chk("estado_t8", estado_a, to_oh(m_st[0]));
    chk("alerta_t8", {3'b0, alerta_a}, 4'(m_al[0]));
    chk("evento_t8", {3'b0, evento_a}, 4'(m_ev[0]));
    chk("estado_t0", estado_z, to_oh(m_st[1]));
    chk("alerta_t0", {3'b0, alerta_z}, 4'(m_al[1]));
    chk("evento_t0", {3'b0, evento_z}, 4'(m_ev[1]));
  end

  task automatic ciclos(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulso_reset();
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("reset_async_estado", estado_a, 4'b0000);
    chk("reset_async_evento", {3'b0, evento_a}, 4'b0000);
    @(posedge clk); #3 rst_n = 1'b1;
  endtask

  initial begin
    int ev_a, ev_z, n_dorm, w;
    bit saw_com, saw_aula;

    ciclos(3);
    chk("rst_estado", estado_a, 4'b0000);
    chk("rst_alerta", {3'b0, alerta_a}, 4'b0000);
    chk("rst_evento", {3'b0, evento_a}, 4'b0000);
    @(posedge clk); #3 rst_n = 1'b1;
    ciclos(5);

    // held b1: one entry; t8 also times out, t0 stays in COMENDO
    b1 = 1'b1; ev_a = 0; ev_z = 0;
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      if (evento_a) ev_a++;
      if (evento_z) ev_z++;
    end
    chk("hold_eventos_t8", 4'(ev_a), 4'd2);
    chk("hold_eventos_t0", 4'(ev_z), 4'd1);
    chk("hold_estado_t0", estado_z, 4'b0010);
    b1 = 1'b0; ciclos(12);
    b1 = 1'b1; ciclos(12);
    chk("repress_t0_idle", estado_z, 4'b0000);
    b1 = 1'b0; ciclos(20);

    // simultaneous b1+b2
    b1 = 1'b1; b2 = 1'b1; ciclos(12);
    chk("aula_t0", estado_z, 4'b0100);
    b1 = 1'b0; b2 = 1'b0; ciclos(10);
    b1 = 1'b1; ciclos(10);
    b1 = 1'b0; ciclos(20);
    chk("aula_exit_t0", estado_z, 4'b0000);

    // b2 one sample period after b1
    saw_com = 0; saw_aula = 0;
    b1 = 1'b1; ciclos(P);
    b2 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (estado_a == 4'b0010) saw_com = 1;
      if (estado_a == 4'b0100) saw_aula = 1;
    end
    chk("stagger_saw_comendo", {3'b0, saw_com}, 4'd1);
    chk("stagger_no_aula", {3'b0, saw_aula}, 4'd0);
    chk("stagger_end_idle", estado_a, 4'b0000);
    b1 = 1'b0; b2 = 1'b0; ciclos(12);

    // DORMINDO timeout length, and no timeout when disabled
    n_dorm = 0;
    b2 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 8) b2 = 1'b0;
      if (estado_a == 4'b0001) n_dorm++;
    end
    chk("dorm_duracao", 4'(n_dorm), 4'd8);
    ciclos(1000);
    chk("dorm_sem_timeout_t0", estado_z, 4'b0001);
    b2 = 1'b1; ciclos(12);
    b2 = 1'b0; ciclos(20);

    // death on the same cycle as a press pulse
    b1 = 1'b1; w = 0;
    while (m_pr[0] == 0 && w < 40) begin @(negedge clk); w++; end
    if (w >= 40) begin n_cmp++; n_bad++; $display("FAIL press_wait timed out"); end
    sono = 8'd0;
    @(negedge clk);
    chk("morte_t8", estado_a, 4'b1000);
    chk("morte_t0", estado_z, 4'b1000);
    b1 = 1'b0; ciclos(10);
    b1 = 1'b1; sono = 8'd100; ciclos(12);
    b1 = 1'b0; ciclos(8);
    chk("morto_absorve", estado_a, 4'b1000);
    chk("morto_alerta", {3'b0, alerta_a}, 4'd0);
    pulso_reset();
    ciclos(3);

    // alert threshold boundaries
    fome = 8'd16; ciclos(2);
    chk("alerta_16", {3'b0, alerta_a}, 4'd1);
    fome = 8'd17; ciclos(2);
    chk("alerta_17", {3'b0, alerta_a}, 4'd0);
    fome = 8'd0; ciclos(1);
    chk("fome0_morto", estado_a, 4'b1000);
    chk("fome0_alerta", {3'b0, alerta_a}, 4'd0);
    fome = 8'd100;
    pulso_reset();
    ciclos(3);

    // asynchronous reset in the middle of COMENDO
    b1 = 1'b1; w = 0;
    while (m_st[0] != 2 && w < 40) begin @(negedge clk); w++; end
    chk("mid_comendo", estado_a, 4'b0010);
    b1 = 1'b0;
    pulso_reset();
    ciclos(5);

    // randomised phase
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk); #1;
      rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 11) == 0) b1 = ~b1;
      if ($urandom_range(0, 11) == 0) b2 = ~b2;
      if ($urandom_range(0, 149) == 0) fome = 8'($urandom_range(0, 30));
      else if ($urandom_range(0, 29) == 0) fome = 8'd100;
      if ($urandom_range(0, 299) == 0) felicidade = 8'($urandom_range(0, 20));
      else if ($urandom_range(0, 29) == 0) felicidade = 8'd100;
      if ($urandom_range(0, 299) == 0) sono = 8'($urandom_range(1, 20));
      else if ($urandom_range(0, 29) == 0) sono = 8'd100;
    end
    rst_n = 1'b1;
    ciclos(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
